// File: rtl/paobiao_countdown.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | paobiao_countdown: presettable MM:SS.cc BCD countdown timer, 100 Hz TICK,   |
// | DONE pulse and ALARM level on expiry. Define AUTO_RELOAD_EN for reload.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module paobiao_countdown #(
  parameter int MH_MAX      = 5,
  parameter int ALARM_TICKS = 200
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       TICK,
  input  logic       LOAD,
  input  logic [3:0] LMH,
  input  logic [3:0] LML,
  input  logic [3:0] LSH,
  input  logic [3:0] LSL,
  input  logic       START,
  input  logic       PAUSE,
  output logic [3:0] MH,
  output logic [3:0] ML,
  output logic [3:0] SH,
  output logic [3:0] SL,
  output logic [3:0] MSH,
  output logic [3:0] MSL,
  output logic       RUN,
  output logic       DONE,
  output logic       ALARM
);

  localparam logic [3:0] c_mh_max      = (MH_MAX > 9) ? 4'd9 : 4'(MH_MAX);
  localparam logic [7:0] c_alarm_last  = 8'(ALARM_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_alarm_cnt;
  logic [3:0] r_pmh, r_pml, r_psh, r_psl;

  logic [3:0] w_lmh, w_lml, w_lsh, w_lsl;
  logic [3:0] w_dmh, w_dml, w_dsh, w_dsl, w_dmsh, w_dmsl;
  logic       w_b0, w_b1, w_b2, w_b3, w_b4;
  logic       w_is_zero, w_is_one;

  always_comb begin
    w_lmh = (LMH > c_mh_max) ? c_mh_max : LMH;
    w_lml = (LML > 4'd9) ? 4'd9 : LML;
    w_lsh = (LSH > 4'd5) ? 4'd5 : LSH;
    w_lsl = (LSL > 4'd9) ? 4'd9 : LSL;
  end

  // Borrow ripples from centiseconds up; seconds-tens wraps to 5.
  always_comb begin
    w_b0   = (MSL == 4'd0);
    w_dmsl = w_b0 ? 4'd9 : MSL - 4'd1;
    w_dmsh = w_b0 ? ((MSH == 4'd0) ? 4'd9 : MSH - 4'd1) : MSH;
    w_b1   = w_b0 && (MSH == 4'd0);
    w_dsl  = w_b1 ? ((SL == 4'd0) ? 4'd9 : SL - 4'd1) : SL;
    w_b2   = w_b1 && (SL == 4'd0);
    w_dsh  = w_b2 ? ((SH == 4'd0) ? 4'd5 : SH - 4'd1) : SH;
    w_b3   = w_b2 && (SH == 4'd0);
    w_dml  = w_b3 ? ((ML == 4'd0) ? 4'd9 : ML - 4'd1) : ML;
    w_b4   = w_b3 && (ML == 4'd0);
    w_dmh  = w_b4 ? MH - 4'd1 : MH;
    w_is_zero = ({MH, ML, SH, SL, MSH, MSL} == 24'h0);
    w_is_one  = ({MH, ML, SH, SL, MSH, MSL} == 24'h1);
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      r_state     <= ST_IDLE;
      r_alarm_cnt <= 8'd0;
      r_pmh <= 4'd0; r_pml <= 4'd0; r_psh <= 4'd0; r_psl <= 4'd0;
      MH  <= 4'd0; ML  <= 4'd0; SH <= 4'd0; SL <= 4'd0;
      MSH <= 4'd0; MSL <= 4'd0;
      RUN <= 1'b0; DONE <= 1'b0; ALARM <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (LOAD) begin
            r_pmh <= w_lmh; r_pml <= w_lml; r_psh <= w_lsh; r_psl <= w_lsl;
            MH  <= w_lmh; ML  <= w_lml; SH <= w_lsh; SL <= w_lsl;
            MSH <= 4'd0;  MSL <= 4'd0;
          end else if (!PAUSE && START && !w_is_zero) begin
            r_state <= ST_RUN;
            RUN     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (PAUSE) begin
            r_state <= ST_HOLD;
            RUN     <= 1'b0;
          end else if (TICK) begin
            if (w_is_one) begin
              DONE <= 1'b1;
`ifdef AUTO_RELOAD_EN
              MH  <= r_pmh; ML  <= r_pml; SH <= r_psh; SL <= r_psl;
              MSH <= 4'd0;  MSL <= 4'd0;
`else
              MSL         <= 4'd0;
              RUN         <= 1'b0;
              ALARM       <= 1'b1;
              r_alarm_cnt <= 8'd0;
              r_state     <= ST_ALARM;
`endif
            end else if (!w_is_zero) begin
              MH  <= w_dmh;  ML  <= w_dml;  SH <= w_dsh; SL <= w_dsl;
              MSH <= w_dmsh; MSL <= w_dmsl;
            end
          end
        end
        ST_ALARM: begin
          if (LOAD) begin
            r_pmh <= w_lmh; r_pml <= w_lml; r_psh <= w_lsh; r_psl <= w_lsl;
            MH  <= w_lmh; ML  <= w_lml; SH <= w_lsh; SL <= w_lsl;
            MSH <= 4'd0;  MSL <= 4'd0;
            ALARM   <= 1'b0;
            r_state <= ST_IDLE;
          end else if (PAUSE) begin
            r_state <= ST_ALARM;
          end else if (START) begin
            ALARM   <= 1'b0;
            r_state <= ST_IDLE;
          end else if (TICK) begin
            if (r_alarm_cnt == c_alarm_last) begin
              ALARM       <= 1'b0;
              r_alarm_cnt <= 8'd0;
              r_state     <= ST_IDLE;
            end else begin
              r_alarm_cnt <= r_alarm_cnt + 8'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          RUN     <= 1'b0;
          ALARM   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_paobiao_countdown.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_paobiao_countdown: directed and random checks of the countdown timer    |
// | against a centisecond-total reference model.                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_paobiao_countdown;

  localparam int MH_MAX      = 5;
  localparam int ALARM_TICKS = 200;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       TICK = 1'b0, LOAD = 1'b0, START = 1'b0, PAUSE = 1'b0;
  logic [3:0] LMH = 4'd0, LML = 4'd0, LSH = 4'd0, LSL = 4'd0;
  logic [3:0] MH, ML, SH, SL, MSH, MSL;
  logic       RUN, DONE, ALARM;

  int compared = 0;
  int mismatched = 0;

  // Reference model: count and preset held as total centiseconds.
  int m_state = 0;  // 0 idle, 1 run, 2 hold, 3 alarm
  int m_cnt = 0, m_pre = 0, m_acnt = 0;
  bit m_done = 1'b0, m_alarm = 1'b0;

  paobiao_countdown #(.MH_MAX(MH_MAX), .ALARM_TICKS(ALARM_TICKS)) dut (
    .CLK(CLK), .CLR(CLR), .TICK(TICK), .LOAD(LOAD),
    .LMH(LMH), .LML(LML), .LSH(LSH), .LSL(LSL),
    .START(START), .PAUSE(PAUSE),
    .MH(MH), .ML(ML), .SH(SH), .SL(SL), .MSH(MSH), .MSL(MSL),
    .RUN(RUN), .DONE(DONE), .ALARM(ALARM)
  );

  always #5 CLK = ~CLK;

  function automatic int lim(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [26:0] dvec();
    return {MH, ML, SH, SL, MSH, MSL, RUN, DONE, ALARM};
  endfunction

  function automatic logic [26:0] mvec();
    int mins, secs, cs;
    mins = m_cnt / 6000;
    secs = (m_cnt / 100) % 60;
    cs   = m_cnt % 100;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
            4'(cs / 10), 4'(cs % 10), (m_state == 1), m_done, m_alarm};
  endfunction

  task automatic model_edge();
    int pre;
    pre = ((lim(int'(LMH), MH_MAX) * 10 + lim(int'(LML), 9)) * 60
          + lim(int'(LSH), 5) * 10 + lim(int'(LSL), 9)) * 100;
    m_done = 1'b0;
    if (!CLR) begin
      m_state = 0; m_cnt = 0; m_pre = 0; m_acnt = 0; m_alarm = 1'b0;
    end else begin
      case (m_state)
        0, 2: begin
          if (LOAD) begin m_pre = pre; m_cnt = pre; end
          else if (!PAUSE && START && m_cnt != 0) m_state = 1;
        end
        1: begin
          if (PAUSE) m_state = 2;
          else if (TICK && m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
              m_done = 1'b1;
`ifdef AUTO_RELOAD_EN
              m_cnt = m_pre;
`else
              m_state = 3; m_alarm = 1'b1; m_acnt = 0;
`endif
            end
          end
        end
        default: begin
          if (LOAD) begin m_pre = pre; m_cnt = pre; m_alarm = 1'b0; m_state = 0; end
          else if (PAUSE) m_state = 3;
          else if (START) begin m_alarm = 1'b0; m_state = 0; end
          else if (TICK) begin
            m_acnt = m_acnt + 1;
            if (m_acnt == ALARM_TICKS) begin m_alarm = 1'b0; m_state = 0; end
          end
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [26:0] obs, input logic [26:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit clr_n, input bit ld, input bit st, input bit ps,
                      input bit tk, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    @(negedge CLK);
    CLR = clr_n; LOAD = ld; START = st; PAUSE = ps; TICK = tk;
    LMH = a; LML = b; LSH = c; LSL = d;
    @(posedge CLK);
    model_edge();
    #1;
    check("model", dvec(), mvec());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset", dvec(), 27'h0);

    // 01:30 countdown
    step(1, 1, 0, 0, 0, 4'd0, 4'd1, 4'd3, 4'd0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    ticks(1);
    check("t2_first", dvec(), {24'h012999, 3'b100});
    ticks(100);
    check("t2_more", dvec(), {24'h012899, 3'b100});

    // reset mid-run, then START with zero count
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    check("clr_midrun", dvec(), 27'h0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    check("start_zero", dvec(), 27'h0);

    // full borrow chain
    step(1, 1, 0, 0, 0, 4'd1, 4'd0, 4'd0, 4'd0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    ticks(1);
    check("t3_borrow", dvec(), {24'h095999, 3'b100});

`ifdef AUTO_RELOAD_EN
    step(1, 0, 1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd1);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    ticks(100);
    check("t6_reload", dvec(), {24'h000100, 3'b110});
    ticks(1);
    check("t6_done_low", dvec(), {24'h000099, 3'b100});
    ticks(99);
    check("t6_second", dvec(), {24'h000100, 3'b110});
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
`else
    step(1, 0, 1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd1);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    ticks(100);
    check("t4_expire", dvec(), {24'h0, 3'b011});
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_done_low", dvec(), {24'h0, 3'b001});
    ticks(ALARM_TICKS - 1);
    check("t4_alarm_hold", dvec(), {24'h0, 3'b001});
    ticks(1);
    check("t4_alarm_end", dvec(), 27'h0);
    step(1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd1);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    ticks(105);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    check("t4_ack", dvec(), 27'h0);
`endif

    // pause/hold and load behaviour
    step(1, 1, 0, 0, 0, 4'd0, 4'd1, 4'd0, 4'd0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    ticks(3);
    step(1, 0, 1, 1, 1, 0, 0, 0, 0);
    check("t5_pause_wins", dvec(), {24'h005997, 3'b000});
    ticks(3);
    check("t5_frozen", dvec(), {24'h005997, 3'b000});
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 4'd0, 4'd2, 4'd2, 4'd2);
    check("t5_load_in_run", dvec(), {24'h005997, 3'b100});
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 4'd9, 4'd3, 4'd7, 4'd12);
    check("t5_clamp", dvec(), {24'h535900, 3'b000});

    // random traffic, presets biased short so expiries and alarms occur
    for (int i = 0; i < 6000; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 3),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
           ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
           ($urandom_range(0, 3) == 0)  ? 4'($urandom_range(0, 15)) : 4'd0,
           4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
